// File: rtl/mac_pkg.sv
// mac_pkg: shared widths and state encoding for the MAC accumulator stage
package mac_pkg;
   localparam int DEF_PROD_W = 16;
   localparam int DEF_ACC_W  = 24;
   localparam int DEF_CNT_W  = 8;
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} mac_acc_state_t;
endpackage

// File: rtl/sat_add.sv
// sat_add: unsigned saturating adder of a product into the running accumulator
module sat_add
   import mac_pkg::*;
#(
   parameter int ACC_W  = DEF_ACC_W,
   parameter int PROD_W = DEF_PROD_W
) (
   input  logic [ACC_W-1:0]  acc_i,
   input  logic [PROD_W-1:0] prod_i,
   output logic [ACC_W-1:0]  sum_o,
   output logic              sat_o
);
   logic [ACC_W:0] full;
   assign full  = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_i};
   assign sat_o = full[ACC_W];
   assign sum_o = sat_o ? '1 : full[ACC_W-1:0];
endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums a frame of products with saturation and hands the result downstream
module mac_accumulator
   import mac_pkg::*;
#(
   parameter int PROD_W = DEF_PROD_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              clear_i,
   input  logic [CNT_W-1:0]  frame_len_i,
   input  logic [PROD_W-1:0] prod_in_i,
   input  logic              prod_valid_i,
   output logic              prod_ready_o,
   output logic [ACC_W-1:0]  acc_out_o,
   output logic              acc_valid_o,
   input  logic              acc_ready_i,
   output logic              overflow_o,
   output logic              busy_o
);
   mac_acc_state_t   state_q;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, len_q;
   logic             ovf_q, sat_d;

   sat_add #(.ACC_W(ACC_W), .PROD_W(PROD_W)) u_sat_add (
      .acc_i (acc_q),
      .prod_i(prod_in_i),
      .sum_o (acc_d),
      .sat_o (sat_d)
   );

   // Frame FSM: clear beats everything except reset; the last accept (count == len-1) moves to DONE
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         ovf_q   <= 1'b0;
      end else if (clear_i) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start_i && frame_len_i != '0) begin
               len_q   <= frame_len_i;
               acc_q   <= '0;
               cnt_q   <= '0;
               ovf_q   <= 1'b0;
               state_q <= ACCUM;
            end
            ACCUM: if (prod_valid_i) begin
               acc_q <= acc_d;
               ovf_q <= ovf_q | sat_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == len_q - 1'b1) state_q <= DONE;
            end
            DONE: if (acc_ready_i) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign prod_ready_o = (state_q == ACCUM);
   assign acc_valid_o  = (state_q == DONE);
   assign busy_o       = (state_q != IDLE);
   assign acc_out_o    = acc_q;
   assign overflow_o   = ovf_q;
endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed scoreboard bench for the frame accumulator (default and 17-bit instances)
module tb_mac_accumulator;
   logic        clk, rst_n, start, clear, prod_valid, acc_ready;
   logic [7:0]  frame_len;
   logic [15:0] prod;
   logic        prod_ready, acc_valid, overflow, busy;
   logic [23:0] acc_out;
   logic        s_prod_ready, s_acc_valid, s_overflow, s_busy;
   logic [16:0] s_acc_out;

   typedef struct {logic [23:0] acc; logic ovf;} exp_t;
   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   bit          sel_small = 0;
   int          m_w = 24;
   logic [63:0] m_sum;
   logic        m_ovf;

   mac_accumulator u_dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .clear_i(clear), .frame_len_i(frame_len),
      .prod_in_i(prod), .prod_valid_i(prod_valid), .prod_ready_o(prod_ready), .acc_out_o(acc_out),
      .acc_valid_o(acc_valid), .acc_ready_i(acc_ready), .overflow_o(overflow), .busy_o(busy)
   );

   mac_accumulator #(.ACC_W(17)) u_small (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .clear_i(clear), .frame_len_i(frame_len),
      .prod_in_i(prod), .prod_valid_i(prod_valid), .prod_ready_o(s_prod_ready), .acc_out_o(s_acc_out),
      .acc_valid_o(s_acc_valid), .acc_ready_i(acc_ready), .overflow_o(s_overflow), .busy_o(s_busy)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   function automatic logic [23:0] o_acc();
      return sel_small ? {7'd0, s_acc_out} : acc_out;
   endfunction
   function automatic logic o_valid();
      return sel_small ? s_acc_valid : acc_valid;
   endfunction
   function automatic logic o_ovf();
      return sel_small ? s_overflow : overflow;
   endfunction
   function automatic logic o_pready();
      return sel_small ? s_prod_ready : prod_ready;
   endfunction
   function automatic logic o_busy();
      return sel_small ? s_busy : busy;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_frame(input logic [7:0] len);
      start = 1;
      frame_len = len;
      tick;
      start = 0;
      m_sum = 0;
      m_ovf = 0;
      chk("busy_after_start", o_busy(), 1);
   endtask

   task automatic feed(input logic [15:0] p, input int gap);
      repeat (gap) tick;
      chk("prod_ready", o_pready(), 1);
      prod = p;
      prod_valid = 1;
      tick;
      prod_valid = 0;
      m_sum = m_sum + p;
      if (m_sum > (64'd1 << m_w) - 1) begin
         m_sum = (64'd1 << m_w) - 1;
         m_ovf = 1;
      end
   endtask

   task automatic end_frame;
      exp_t e;
      int   n;
      sb.push_back('{m_sum[23:0], m_ovf});
      n = 0;
      while (!o_valid() && n < 20) begin
         tick;
         n++;
      end
      chk("valid_latency", n, 0);
      e = sb.pop_front();
      chk("acc_out", o_acc(), e.acc);
      chk("overflow", o_ovf(), e.ovf);
      chk("prod_ready_done", o_pready(), 0);
   endtask

   task automatic handshake;
      acc_ready = 1;
      tick;
      acc_ready = 0;
      chk("hs_valid_drop", o_valid(), 0);
      chk("hs_idle", o_busy(), 0);
   endtask

   initial begin
      rst_n = 0; start = 0; clear = 0; prod_valid = 0; acc_ready = 0; frame_len = 0; prod = 0;
      repeat (2) tick;
      chk("rst_acc_out", acc_out, 0);
      chk("rst_acc_valid", acc_valid, 0);
      chk("rst_prod_ready", prod_ready, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1;
      tick;
      // reset in the middle of a frame discards the partial sum at once
      start_frame(3);
      feed(5, 0);
      feed(7, 0);
      rst_n = 0;
      #2;
      chk("midrst_acc", acc_out, 0);
      chk("midrst_prod_ready", prod_ready, 0);
      chk("midrst_busy", busy, 0);
      tick;
      chk("midrst_valid", acc_valid, 0);
      chk("midrst_ovf", overflow, 0);
      rst_n = 1;
      tick;
      // basic frame with idle gaps, then a stalled consumer
      start_frame(3);
      feed(100, 1);
      feed(200, 1);
      feed(300, 1);
      end_frame;
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("stall_valid", acc_valid, 1);
         chk("stall_acc", acc_out, 600);
      end
      handshake;
      chk("idle_hold", acc_out, 600);
      // zero-length start is ignored
      start = 1;
      frame_len = 0;
      tick;
      start = 0;
      chk("len0_busy", busy, 0);
      chk("len0_acc", acc_out, 600);
      chk("len0_ready", prod_ready, 0);
      // start during ACCUM ignored, acc_ready high early, start during handshake ignored
      start_frame(2);
      feed(10, 0);
      start = 1;
      frame_len = 5;
      tick;
      start = 0;
      acc_ready = 1;
      feed(20, 0);
      end_frame;
      start = 1;
      frame_len = 4;
      tick;
      start = 0;
      acc_ready = 0;
      chk("hs_start_busy", busy, 0);
      chk("hs_start_valid", acc_valid, 0);
      // saturation on the 17-bit instance, sticky until the next start
      sel_small = 1;
      m_w = 17;
      start_frame(3);
      feed(16'hFFFF, 0);
      feed(16'hFFFF, 0);
      feed(16'hFFFF, 0);
      end_frame;
      handshake;
      chk("ovf_sticky_idle", s_overflow, 1);
      start_frame(1);
      chk("ovf_cleared_on_start", s_overflow, 0);
      feed(1, 0);
      end_frame;
      handshake;
      sel_small = 0;
      m_w = 24;
      // clear beats a simultaneous accept
      start_frame(3);
      feed(50, 0);
      prod = 70;
      prod_valid = 1;
      clear = 1;
      tick;
      clear = 0;
      prod_valid = 0;
      chk("clr_busy", busy, 0);
      chk("clr_acc", acc_out, 0);
      chk("clr_ovf", overflow, 0);
      chk("clr_ready", prod_ready, 0);
      chk("clr_valid", acc_valid, 0);
      // longest frame: the counter must reach DONE without wrapping
      start_frame(8'd255);
      for (int i = 0; i < 255; i++) feed(16'd1, 0);
      end_frame;
      handshake;
      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
Downstream stage of the shift-add multiplier result register in the MAC datapath.
- Consumes each completed 16-bit product and sums a frame of frame_len products into a saturating accumulator.
- Presents the frame result on a valid/ready output handshake.
- Backpressures the multiplier controller via prod_ready.

Parameters:
PROD_W, 16, product width (matches multiplier mult_out)
ACC_W, 24, accumulator width; must be >= PROD_W
CNT_W, 8, frame length counter width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset
start  input  1  begin a new frame; sampled only in IDLE
clear  input  1  synchronous abort/zero; highest priority after reset
frame_len  input  CNT_W  products per frame; sampled on accepted start
prod_in  input  PROD_W  unsigned product from multiplier
prod_valid  input  1  prod_in is valid this cycle
prod_ready  output  1  block accepts a product this cycle
acc_out  output  ACC_W  accumulated frame result
acc_valid  output  1  acc_out holds a completed frame result
acc_ready  input  1  consumer accepts acc_out
overflow  output  1  sticky: saturation occurred in the current/last frame
busy  output  1  high in ACCUM or DONE

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; acc, count and len_q zero.
  - acc_out=0, acc_valid=0, prod_ready=0, overflow=0, busy=0.
- States: IDLE, ACCUM, DONE (enum in package).
- IDLE:
  - prod_ready=0, acc_valid=0; acc_out holds the last result.
  - start=1 and frame_len!=0 -> latch len_q=frame_len, acc=0, count=0, overflow=0; next state ACCUM.
  - start=1 with frame_len=0 is ignored: no state change, registers untouched.
- ACCUM:
  - prod_ready=1.
  - An accept is prod_valid and prod_ready in the same cycle. On accept: acc <= sat(acc + zero-extended prod_in); count <= count+1.
  - Saturation: if the ACC_W+1-bit sum exceeds 2^ACC_W-1, acc becomes all ones and overflow is set. overflow stays set until the next accepted start, clear, or reset.
  - Accept with count==len_q-1 -> DONE. acc_valid rises the cycle after the last accept (latency 1).
  - prod_valid=0 stalls the block indefinitely with no timeout.
- DONE:
  - acc_valid=1, prod_ready=0; acc_out stable while acc_valid and not acc_ready.
  - acc_ready=1 -> IDLE the next cycle; acc_valid drops.
  - acc_ready may be high before acc_valid; the transfer completes in the first DONE cycle.
- start outside IDLE is ignored. start in the same cycle as the DONE->IDLE handshake is also ignored; a new frame needs start while in IDLE.
- clear=1 in any state, synchronous:
  - next state IDLE; acc, count and overflow zero; acc_valid=0.
  - Overrides a simultaneous accept, handshake or start.
- Reset asserted mid-frame discards the partial sum immediately.
- frame_len=2^CNT_W-1 maximum: count must not wrap before the DONE transition.
- No combinational path from prod_valid to prod_ready, or from acc_ready to acc_valid. Both outputs are decoded from registered state only.

Decomposition:
- Package mac_pkg: PROD_W/ACC_W/CNT_W defaults, state enum type mac_acc_state_t.
- Sub-module sat_add: purely combinational unsigned saturating adder (ACC_W + PROD_W -> ACC_W, plus sat flag). It is instantiated once.
- The FSM, counter and registers live in mac_accumulator.

Test Plan:
- Reset mid-ACCUM after two products -> all outputs 0 next edge, state IDLE, prod_ready=0.
- start with frame_len=3; products 100, 200, 300 with one idle cycle between each -> acc_valid one cycle after third accept, acc_out=600, overflow=0.
- acc_ready held low 5 cycles in DONE -> acc_out stays 600 and acc_valid=1 throughout; acc_ready=1 -> IDLE next cycle.
- ACC_W=17, frame_len=3, three products of 0xFFFF -> acc_out=0x1FFFF, overflow=1. Next start clears overflow.
- Misuse cases:
  - frame_len=0 with start -> stays IDLE, busy=0.
  - start pulsed during ACCUM -> frame unaffected.
- clear asserted in the same cycle as an accept in ACCUM -> IDLE, acc_out=0, overflow=0; the product is discarded.
